// File: rtl/icache_if.sv
// Refill bus between the instruction cache and instruction memory.
// The cache drives one word-aligned beat address; memory returns one word per ack.
interface icache_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
   modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 0-cycle hits, word-per-beat line refill on a miss.
// Define ICACHE_STATS_EN to add the hit_count/miss_count outputs.
module icache #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic        clock,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        req,
   input  logic        inv,
   output logic [31:0] instruction,
   output logic        hit,
   output logic        stall,
   icache_if.master    mem
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);
   localparam int OB = $clog2(WORDS) + 2;
   localparam int IB = $clog2(LINES);
   localparam int TW = 32 - OB - IB;
   localparam int BW = $clog2(WORDS);
   localparam int LW = 32 - OB;

   typedef enum logic {IDLE, REFILL} state_e;

   state_e                            state_q, state_d;
   logic [LINES-1:0]                  valid_q, valid_d;
   logic [LINES-1:0][TW-1:0]          tag_q, tag_d;
   logic [LINES-1:0][WORDS-1:0][31:0] data_q;
   logic [LW-1:0]                     line_q, line_d;
   logic [BW-1:0]                     beat_q, beat_d;
   logic                              poison_q, poison_d;
   logic                              data_we;

   logic [BW-1:0] pc_off;
   logic [IB-1:0] pc_idx;
   logic [TW-1:0] pc_tag;
   logic [IB-1:0] fill_idx;
   logic          lookup_hit;
   logic          unused_pc;

   assign pc_off     = pc[OB-1:2];
   assign pc_idx     = pc[OB+IB-1:OB];
   assign pc_tag     = pc[31:OB+IB];
   assign unused_pc  = ^pc[1:0];
   assign fill_idx   = line_q[IB-1:0];
   assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

   // Outputs are gated by rst so a request held during reset cannot raise stall.
   always_comb begin
      hit          = 1'b0;
      stall        = 1'b0;
      instruction  = '0;
      mem.mem_req  = 1'b0;
      mem.mem_addr = '0;
      if (rst) begin
         if (state_q == REFILL) begin
            stall        = 1'b1;
            mem.mem_req  = 1'b1;
            mem.mem_addr = {line_q, beat_q, 2'b00};
         end else if (req) begin
            hit   = lookup_hit;
            stall = !lookup_hit;
            if (lookup_hit) instruction = data_q[pc_idx][pc_off];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      tag_d    = tag_q;
      line_d   = line_q;
      beat_d   = beat_q;
      poison_d = poison_q;
      data_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && !lookup_hit) begin
               state_d = REFILL;
               line_d  = pc[31:OB];
               beat_d  = '0;
            end
         end
         REFILL: begin
            if (inv) poison_d = 1'b1;
            if (mem.mem_ack) begin
               data_we = 1'b1;
               beat_d  = beat_q + 1'b1;
               if (beat_q == BW'(WORDS - 1)) begin
                  tag_d[fill_idx] = line_q[LW-1:IB];
                  if (!poison_q) valid_d[fill_idx] = 1'b1;
                  state_d  = IDLE;
                  poison_d = 1'b0;
                  beat_d   = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Applied last so an invalidate on the final beat still leaves the line invalid.
      if (inv) valid_d = '0;
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   always_comb begin
      hit_count_d  = hit_count_q + (hit ? 32'd1 : 32'd0);
      miss_count_d = miss_count_q +
                     ((state_q == IDLE && state_d == REFILL) ? 32'd1 : 32'd0);
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         tag_q        <= '0;
         line_q       <= '0;
         beat_q       <= '0;
         poison_q     <= 1'b0;
`ifdef ICACHE_STATS_EN
         hit_count_q  <= '0;
         miss_count_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         tag_q        <= tag_d;
         line_q       <= line_d;
         beat_q       <= beat_d;
         poison_q     <= poison_d;
`ifdef ICACHE_STATS_EN
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
`endif
      end
   end

   // Data words need no reset: they are only observable behind a set valid bit.
   always_ff @(posedge clock) begin
      if (data_we) data_q[fill_idx][beat_q] <= mem.mem_rdata;
   end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache with an address-level cache model checked every cycle.
module tb_icache;
   localparam int LINES = 16;
   localparam int WORDS = 4;
   localparam int LB    = WORDS * 4;

   logic        clock = 1'b0;
   logic        rst   = 1'b0;
   logic [31:0] pc    = '0;
   logic        req   = 1'b0;
   logic        inv   = 1'b0;
   logic [31:0] instruction;
   logic        hit, stall;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   icache_if mif ();

   icache #(.LINES(LINES), .WORDS(WORDS)) dut (
      .clock(clock), .rst(rst), .pc(pc), .req(req), .inv(inv),
      .instruction(instruction), .hit(hit), .stall(stall), .mem(mif)
`ifdef ICACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 clock = ~clock;

   // Memory contents are a fixed function of the word address.
   assign mif.mem_rdata = mif.mem_addr ^ 32'hDEAD_0000;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", n, act, exp);
      end
   endtask

   // ---- model: which line base address each index holds, plus the pending beat addresses
   bit          m_valid [LINES];
   logic [31:0] m_line  [LINES];
   bit          m_fill   = 1'b0;
   bit          m_poison = 1'b0;
   logic [31:0] m_base   = '0;
   logic [31:0] m_q[$];
   logic [31:0] m_hits   = '0;
   logic [31:0] m_misses = '0;

   function automatic int idx_of(input logic [31:0] a);
      return int'((a / LB) % LINES);
   endfunction

   function automatic logic [31:0] base_of(input logic [31:0] a);
      return a & ~32'(LB - 1);
   endfunction

   function automatic bit m_lookup();
      return req && m_valid[idx_of(pc)] && (m_line[idx_of(pc)] == base_of(pc));
   endfunction

   initial forever begin
      @(posedge clock or negedge rst);
      if (!rst) begin
         foreach (m_valid[i]) m_valid[i] = 1'b0;
         m_fill = 1'b0; m_poison = 1'b0; m_q.delete();
         m_hits = '0; m_misses = '0;
      end else begin
         bit lh;
         lh = !m_fill && m_lookup();
         if (lh) m_hits++;
         if (m_fill) begin
            if (inv) m_poison = 1'b1;
            if (mif.mem_ack) begin
               void'(m_q.pop_front());
               if (m_q.size() == 0) begin
                  if (!m_poison) begin
                     m_valid[idx_of(m_base)] = 1'b1;
                     m_line[idx_of(m_base)]  = m_base;
                  end
                  m_fill = 1'b0; m_poison = 1'b0;
               end
            end
         end else if (req && !lh) begin
            m_fill = 1'b1; m_base = base_of(pc); m_misses++;
            for (int k = 0; k < WORDS; k++) m_q.push_back(m_base + 32'(4 * k));
         end
         if (inv) foreach (m_valid[i]) m_valid[i] = 1'b0;
      end
   end

   // ---- per-cycle compare plus stall/beat recording
   int          stall_cnt = 0;
   logic [31:0] acked[$];

   initial forever begin
      bit          e_hit, e_stall, e_req;
      logic [31:0] e_ins, e_addr;
      @(negedge clock);
      e_hit = 0; e_stall = 0; e_req = 0; e_ins = '0; e_addr = '0;
      if (rst) begin
         if (m_fill) begin
            e_stall = 1; e_req = 1; e_addr = m_q[0];
         end else if (req) begin
            e_hit   = m_lookup();
            e_stall = !e_hit;
            if (e_hit) e_ins = (pc & ~32'd3) ^ 32'hDEAD_0000;
         end
      end
      chk("hit", 32'(hit), 32'(e_hit));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("instruction", instruction, e_ins);
      chk("mem_req", 32'(mif.mem_req), 32'(e_req));
      chk("mem_addr", mif.mem_addr, e_addr);
`ifdef ICACHE_STATS_EN
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_misses);
`endif
      if (stall) stall_cnt++;
      if (mif.mem_req && mif.mem_ack) acked.push_back(mif.mem_addr);
   end

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic clr();
      stall_cnt = 0; acked.delete();
   endtask

   logic [31:0] exp1 [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};

   initial begin
      mif.mem_ack = 1'b1;
      req = 1'b1; pc = 32'h104;
      #12;
      // reset: a missing request must not raise anything
      chk("rst_hit", 32'(hit), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
      chk("rst_mem_addr", mif.mem_addr, 32'h0);
      chk("rst_instr", instruction, 32'h0);
      tick(); rst = 1'b1; clr();

      // cold miss, zero-wait memory
      repeat (5) tick();
      #1;
      chk("cold_stall_cycles", 32'(stall_cnt), 32'd5);
      chk("cold_beats", 32'(acked.size()), 32'd4);
      for (int k = 0; k < 4 && k < acked.size(); k++) chk("cold_addr", acked[k], exp1[k]);
      chk("cold_hit", 32'(hit), 32'd1);
      chk("cold_instr", instruction, 32'hDEAD_0104);

      // spatial hit
      pc = 32'h10C; #1;
      chk("spat_hit", 32'(hit), 32'd1);
      chk("spat_stall", 32'(stall), 32'd0);
      chk("spat_mem_req", 32'(mif.mem_req), 32'd0);
      chk("spat_instr", instruction, 32'hDEAD_010C);
      tick();

      // conflict on index 0
      pc = 32'h204; clr(); #1;
      chk("conf_stall", 32'(stall), 32'd1);
      repeat (5) tick(); #1;
      chk("conf_cycles", 32'(stall_cnt), 32'd5);
      if (acked.size() == 4) begin
         chk("conf_addr0", acked[0], 32'h200);
         chk("conf_addr3", acked[3], 32'h20C);
      end else chk("conf_beats", 32'(acked.size()), 32'd4);
      chk("conf_instr", instruction, 32'hDEAD_0204);
      pc = 32'h104; #1;
      chk("conf_back_hit", 32'(hit), 32'd0);
      chk("conf_back_stall", 32'(stall), 32'd1);
      repeat (5) tick();

      // wait states: ack every third refill cycle
      pc = 32'h348; mif.mem_ack = 1'b0; clr();
      tick();
      for (int r = 0; r < 12; r++) begin
         mif.mem_ack = (r % 3 == 2);
         tick();
      end
      mif.mem_ack = 1'b1; #1;
      chk("wait_cycles", 32'(stall_cnt), 32'd13);
      chk("wait_beats", 32'(acked.size()), 32'd4);
      if (acked.size() > 1) chk("wait_addr1", acked[1], 32'h344);
      chk("wait_hit", 32'(hit), 32'd1);
      chk("wait_instr", instruction, 32'hDEAD_0348);
      tick();

      // invalidate during the second beat
      req = 1'b0; inv = 1'b1; tick();
      inv = 1'b0; req = 1'b1; pc = 32'h104;
      tick(); tick();
      inv = 1'b1; tick();
      inv = 1'b0; tick(); tick(); #1;
      chk("pois_hit", 32'(hit), 32'd0);
      chk("pois_stall", 32'(stall), 32'd1);
      repeat (5) tick(); #1;
      chk("refetch_instr", instruction, 32'hDEAD_0104);
`ifdef ICACHE_STATS_EN
      chk("miss_count_lit", miss_count, 32'd6);
`endif
      tick();

      // reset during beat 2
      req = 1'b0; inv = 1'b1; tick();
      inv = 1'b0; req = 1'b1; pc = 32'h104;
      tick(); tick(); tick();
      chk("pre_rst_mem_req", 32'(mif.mem_req), 32'd1);
      rst = 1'b0; #1;
      chk("async_mem_req", 32'(mif.mem_req), 32'd0);
      chk("async_stall", 32'(stall), 32'd0);
      chk("async_mem_addr", mif.mem_addr, 32'h0);
      tick(); tick();
      rst = 1'b1; #1;
      chk("post_rst_hit", 32'(hit), 32'd0);
      chk("post_rst_stall", 32'(stall), 32'd1);
      repeat (5) tick(); #1;
      chk("post_rst_instr", instruction, 32'hDEAD_0104);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
